// File: rtl/sram_1kb_1rw1r.sv
// Behavioural 1RW+1R synchronous SRAM with registered outputs.
// Define SRAM_WRITE_BYPASS_EN to forward din0 to dout1 on a same-address collision.
module sram_1kb_1rw1r #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int RAM_DEPTH  = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  csb0,
    input  logic                  web0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] din0,
    output logic [DATA_WIDTH-1:0] dout0,
    input  logic                  csb1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    output logic [DATA_WIDTH-1:0] dout1
);

    localparam int IW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(RAM_DEPTH);

`ifdef SRAM_WRITE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

    logic [DATA_WIDTH-1:0] dout0_q, dout0_d;
    logic [DATA_WIDTH-1:0] dout1_q, dout1_d;

    logic          in0, in1;
    logic [IW-1:0] idx0, idx1;
    logic          we0, re0, re1, coll;

    // Range check happens on the full address so high bits never alias.
    assign in0  = {1'b0, addr0} < DEPTH_L;
    assign in1  = {1'b0, addr1} < DEPTH_L;
    assign idx0 = addr0[IW-1:0];
    assign idx1 = addr1[IW-1:0];

    assign we0  = rst_n && !csb0 && !web0 && in0;
    assign re0  = !csb0 && web0;
    assign re1  = !csb1;
    assign coll = we0 && in1 && (addr0 == addr1);

    always_comb begin
        dout0_d = dout0_q;
        dout1_d = dout1_q;
        if (!rst_n) begin
            dout0_d = '0;
            dout1_d = '0;
        end else begin
            if (re0) begin
                dout0_d = in0 ? mem[idx0] : '0;
            end
            if (re1) begin
                if (!in1) begin
                    dout1_d = '0;
                end else if (BYPASS && coll) begin
                    dout1_d = din0;
                end else begin
                    dout1_d = mem[idx1];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        dout0_q <= dout0_d;
        dout1_q <= dout1_d;
    end

    // Array is never reset; only gated writes touch it.
    always_ff @(posedge clk) begin
        if (we0) begin
            mem[idx0] <= din0;
        end
    end

    assign dout0 = dout0_q;
    assign dout1 = dout1_q;

endmodule

// File: tb/tb_sram_1kb_1rw1r.sv
// Scoreboard bench for sram_1kb_1rw1r (DATA_WIDTH=32, ADDR_WIDTH=9, RAM_DEPTH=256).
module tb_sram_1kb_1rw1r;

    localparam int DW = 32;
    localparam int AW = 9;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          csb0, web0, csb1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] din0, dout0, dout1;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        int          due;
        bit          port;
        logic [31:0] exp;
        string       tag;
    } sb_t;

    sb_t sb[$];

    sram_1kb_1rw1r #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .RAM_DEPTH (256)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .csb0 (csb0),
        .web0 (web0),
        .addr0(addr0),
        .din0 (din0),
        .dout0(dout0),
        .csb1 (csb1),
        .addr1(addr1),
        .dout1(dout1)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic expect_out(input bit port, input logic [31:0] exp,
                              input string tag);
        sb_t e;
        e.due  = cyc + 1;
        e.port = port;
        e.exp  = exp;
        e.tag  = tag;
        sb.push_back(e);
    endtask

    task automatic tick();
        sb_t e;
        @(posedge clk);
        #1;
        cyc++;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            check_eq(e.tag, e.port ? dout1 : dout0, e.exp);
        end
    endtask

    task automatic idle();
        csb0 = 1'b1;
        web0 = 1'b1;
        csb1 = 1'b1;
    endtask

    task automatic wr0(input logic [AW-1:0] a, input logic [DW-1:0] d);
        csb0  = 1'b0;
        web0  = 1'b0;
        addr0 = a;
        din0  = d;
    endtask

    task automatic rd0(input logic [AW-1:0] a);
        csb0  = 1'b0;
        web0  = 1'b1;
        addr0 = a;
    endtask

    task automatic rd1(input logic [AW-1:0] a);
        csb1  = 1'b0;
        addr1 = a;
    endtask

    initial begin
        logic [31:0] coll_exp;
`ifdef SRAM_WRITE_BYPASS_EN
        coll_exp = 32'h22;
`else
        coll_exp = 32'h11;
`endif
        // Reset held with a write presented on port 0
        rst_n = 1'b0;
        csb1  = 1'b1;
        addr1 = '0;
        wr0(9'd5, 32'hAAAA_AAAA);
        for (int i = 0; i < 2; i++) begin
            tick();
            check_eq("rst_dout0", dout0, 32'h0);
            check_eq("rst_dout1", dout1, 32'h0);
        end
        rst_n = 1'b1;
        rd0(9'd5);
        tick();
        check_eq("rst_no_write", {31'b0, dout0 !== 32'hAAAA_AAAA}, 32'h1);

        // Write then dual read
        wr0(9'd3, 32'h1234_5678);
        tick();
        rd0(9'd3);
        rd1(9'd3);
        expect_out(1'b0, 32'h1234_5678, "rd_p0");
        expect_out(1'b1, 32'h1234_5678, "rd_p1");
        tick();

        // Hold while deselected, addresses wandering
        for (int i = 0; i < 3; i++) begin
            idle();
            web0  = 1'b0;
            addr0 = 9'(i + 10);
            addr1 = 9'(i + 20);
            din0  = 32'hFFFF_FFFF;
            expect_out(1'b0, 32'h1234_5678, "hold_p0");
            expect_out(1'b1, 32'h1234_5678, "hold_p1");
            tick();
        end
        idle();
        rd0(9'd10);
        expect_out(1'b0, 32'hx, "unused");
        void'(sb.pop_back());
        tick();

        // Fill, then back-to-back sweep on port 1
        idle();
        for (int i = 0; i < 256; i++) begin
            wr0(9'(i), 32'(i));
            tick();
        end
        idle();
        rd0(9'd3);
        expect_out(1'b0, 32'd3, "overwrite_3");
        tick();
        wr0(9'd4, 32'hBEEF);
        expect_out(1'b0, 32'd3, "wr_holds_dout0");
        tick();
        wr0(9'd4, 32'd4);
        tick();
        idle();
        for (int i = 0; i < 256; i++) begin
            rd1(9'(i));
            expect_out(1'b1, 32'(i), $sformatf("sweep_%0d", i));
            tick();
        end
        idle();
        tick();

        // Out-of-range write must not alias onto 300-256=44
        wr0(9'd300, 32'hDEAD);
        tick();
        rd0(9'd300);
        rd1(9'd44);
        expect_out(1'b0, 32'h0, "oor_rd_p0");
        expect_out(1'b1, 32'd44, "alias_p1");
        tick();
        rd0(9'd44);
        rd1(9'd511);
        expect_out(1'b0, 32'd44, "alias_p0");
        expect_out(1'b1, 32'h0, "oor_rd_p1");
        tick();

        // Collision
        idle();
        wr0(9'd7, 32'h11);
        tick();
        wr0(9'd7, 32'h22);
        rd1(9'd7);
        expect_out(1'b1, coll_exp, "collision");
        tick();
        idle();
        rd1(9'd7);
        expect_out(1'b1, 32'h22, "post_collision");
        tick();
        wr0(9'd300, 32'h55);
        rd1(9'd300);
        expect_out(1'b1, 32'h0, "oor_collision");
        tick();

        // Reset mid-run overrides both ports
        rst_n = 1'b0;
        wr0(9'd8, 32'h99);
        rd1(9'd7);
        expect_out(1'b0, 32'h0, "rst2_p0");
        expect_out(1'b1, 32'h0, "rst2_p1");
        tick();
        rst_n = 1'b1;
        idle();
        rd1(9'd8);
        expect_out(1'b1, 32'd8, "rst2_no_write");
        tick();
        idle();
        tick();
        tick();
        check_eq("sb_drain", 32'(sb.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
